// File: rtl/stencil_pkg.sv
// stencil_pkg
//   Shared definitions for the stencil coprocessor read-side sequencer.
//   - SIZE_W      : width of the grid edge length and row/column counters
//   - WORD_BYTES  : bytes per grid word (row stride = SIZE * WORD_BYTES)
//   - state_t     : sequencer FSM states
//   - tag_t       : word plus its grid position and end-of-row/frame flags
package stencil_pkg;

    localparam int SIZE_W     = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [31:0]       data;
        logic [SIZE_W-1:0] row;
        logic [SIZE_W-1:0] col;
        logic              eol;
        logic              eof;
    } tag_t;

endpackage

// File: rtl/stencil_skid.sv
// stencil_skid
//   Two-entry valid/ready register slice. Output is always taken from a
//   register, and in_ready is itself a register derived from the occupancy
//   the slice will have after the current cycle, so neither side sees a
//   combinational path through the slice. Two entries are enough to absorb
//   the one word that can land while in_ready is still high after the
//   downstream stalls, so no word is dropped and 1 word/cycle is sustained.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/in_valid      upstream payload and valid
//   in_ready              upstream ready (registered)
//   out_data/out_valid    downstream payload and valid (registered)
//   out_ready             downstream ready
module stencil_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] ent0;   // head, drives the output
    logic [W-1:0] ent1;   // overflow entry, only used while head is stalled
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         push;
    logic         pop;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = ent0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0     <= '0;
            ent1     <= '0;
            cnt      <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            cnt      <= cnt_nxt;
            in_ready <= (cnt_nxt != 2'd2);
            // in_ready is low whenever cnt==2, so a pop from a full slice
            // never coincides with a push.
            if (pop && cnt == 2'd2)
                ent0 <= ent1;
            else if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
                ent0 <= in_data;
            if (push && cnt == 2'd1 && !pop)
                ent1 <= in_data;
        end
    end

endmodule

// File: rtl/stencil_row_reader.sv
// stencil_row_reader
//   Read-side sequencer of the stencil coprocessor. On GO it splits a
//   SIZE x SIZE grid of 32-bit words starting at SRC into one FIFO read
//   request per row, then forwards the FIFO read stream through a 2-entry
//   skid stage, tagging every word with its row/column and EOL/EOF flags.
//   DONE rises the cycle after the EOF word is taken by the datapath and
//   stays high until the next accepted GO.
// Build option:
//   STENCIL_ROW_PREFETCH_EN  when defined, the next row may be requested
//                            while up to one earlier row is still streaming
//                            in (at most 2 rows outstanding). When undefined,
//                            a row is requested only after every word of the
//                            previous rows has entered the skid stage.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   GO, SIZE, SRC                 start pulse, edge length, byte address
//   DONE                          frame fully delivered (level)
//   READ_ADDR/COUNT/REQ, READ_BUSY   row request to the FIFO read engine
//   READ_DATA/VALID/READY         FIFO read stream
//   OUT_DATA/ROW/COL/EOL/EOF      tagged word to the datapath
//   OUT_VALID, OUT_READY          datapath handshake
module stencil_row_reader
    import stencil_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              GO,
    input  logic [SIZE_W-1:0] SIZE,
    input  logic [31:0]       SRC,
    output logic              DONE,
    output logic [31:0]       READ_ADDR,
    output logic [15:0]       READ_COUNT,
    output logic              READ_REQ,
    input  logic              READ_BUSY,
    input  logic [31:0]       READ_DATA,
    input  logic              READ_VALID,
    output logic              READ_READY,
    output logic [31:0]       OUT_DATA,
    output logic [SIZE_W-1:0] OUT_ROW,
    output logic [SIZE_W-1:0] OUT_COL,
    output logic              OUT_EOL,
    output logic              OUT_EOF,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    state_t            state;
    state_t            state_nxt;
    logic [SIZE_W-1:0] size_q;
    logic [31:0]       row_addr;
    logic [SIZE_W-1:0] req_row;   // rows requested so far
    logic [SIZE_W-1:0] in_row;    // rows fully accepted into the skid
    logic [SIZE_W-1:0] in_col;
    logic              done_q;
    logic              read_req;
    logic              permit;
    logic [31:0]       stride;

    logic              skid_in_valid;
    logic              skid_in_ready;
    tag_t              in_tag;
    tag_t              out_tag;
    logic              in_fire;
    logic              in_eol;
    logic              in_eof;
    logic              eof_fire;

    // Stride is computed in 32 bits; overflow bits are simply dropped.
    assign stride = 32'(size_q) * 32'(WORD_BYTES);

    assign skid_in_valid = READ_VALID && (state != IDLE);
    assign READ_READY    = skid_in_ready && (state != IDLE);
    assign in_fire       = READ_VALID && READ_READY;
    assign in_eol        = (in_col == size_q - SIZE_W'(1));
    assign in_eof        = in_eol && (in_row == size_q - SIZE_W'(1));
    assign eof_fire      = OUT_VALID && OUT_READY && OUT_EOF;

`ifdef STENCIL_ROW_PREFETCH_EN
    // Delivered rows are counted at the input-side EOL handshake (in_row).
    assign permit = ((req_row - in_row) < SIZE_W'(2));
`else
    assign permit = (in_row == req_row);
`endif

    assign in_tag = '{data: READ_DATA, row: in_row, col: in_col,
                      eol: in_eol, eof: in_eof};

    stencil_skid #(.W($bits(tag_t))) u_skid (
        .clk       (CLK),
        .rst       (RST),
        .in_data   (in_tag),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (out_tag),
        .out_valid (OUT_VALID),
        .out_ready (OUT_READY)
    );

    assign OUT_DATA   = out_tag.data;
    assign OUT_ROW    = out_tag.row;
    assign OUT_COL    = out_tag.col;
    assign OUT_EOL    = out_tag.eol;
    assign OUT_EOF    = out_tag.eof;
    assign READ_ADDR  = row_addr;
    assign READ_COUNT = 16'(size_q);
    assign READ_REQ   = read_req;
    assign DONE       = done_q;

    always_comb begin
        state_nxt = state;
        read_req  = 1'b0;
        case (state)
            IDLE:  if (GO && SIZE != '0) state_nxt = ISSUE;
            ISSUE: if (!READ_BUSY) begin
                       read_req  = 1'b1;
                       state_nxt = WAIT;
                   end
            WAIT:  if (req_row == size_q) state_nxt = FLUSH;
                   else if (permit)       state_nxt = ISSUE;
            FLUSH: state_nxt = FLUSH;
            default: state_nxt = IDLE;
        endcase
        // The EOF word ends the frame whichever state the sequencer is in.
        if (state != IDLE && eof_fire)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            size_q   <= '0;
            row_addr <= '0;
            req_row  <= '0;
            in_row   <= '0;
            in_col   <= '0;
            done_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && GO) begin
                size_q   <= SIZE;
                row_addr <= SRC;
                req_row  <= '0;
                in_row   <= '0;
                in_col   <= '0;
                // An empty grid completes immediately without any request.
                done_q   <= (SIZE == '0);
            end else begin
                if (read_req) begin
                    row_addr <= row_addr + stride;
                    req_row  <= req_row + SIZE_W'(1);
                end
                if (in_fire) begin
                    if (in_eol) begin
                        in_col <= '0;
                        in_row <= in_row + SIZE_W'(1);
                    end else begin
                        in_col <= in_col + SIZE_W'(1);
                    end
                end
                if (state != IDLE && eof_fire)
                    done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stencil_row_reader.sv
`timescale 1ns/1ps
module tb_stencil_row_reader;
    import stencil_pkg::*;

    logic              CLK = 1'b0;
    logic              RST;
    logic              GO;
    logic [SIZE_W-1:0] SIZE;
    logic [31:0]       SRC;
    logic              DONE;
    logic [31:0]       READ_ADDR;
    logic [15:0]       READ_COUNT;
    logic              READ_REQ;
    logic              READ_BUSY;
    logic [31:0]       READ_DATA;
    logic              READ_VALID;
    logic              READ_READY;
    logic [31:0]       OUT_DATA;
    logic [SIZE_W-1:0] OUT_ROW;
    logic [SIZE_W-1:0] OUT_COL;
    logic              OUT_EOL;
    logic              OUT_EOF;
    logic              OUT_VALID;
    logic              OUT_READY;

    always #5 CLK = ~CLK;

    stencil_row_reader dut (
        .CLK(CLK), .RST(RST), .GO(GO), .SIZE(SIZE), .SRC(SRC), .DONE(DONE),
        .READ_ADDR(READ_ADDR), .READ_COUNT(READ_COUNT), .READ_REQ(READ_REQ),
        .READ_BUSY(READ_BUSY), .READ_DATA(READ_DATA), .READ_VALID(READ_VALID),
        .READ_READY(READ_READY), .OUT_DATA(OUT_DATA), .OUT_ROW(OUT_ROW),
        .OUT_COL(OUT_COL), .OUT_EOL(OUT_EOL), .OUT_EOF(OUT_EOF),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] row;
        logic [15:0] col;
        logic        eol;
        logic        eof;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    logic [31:0] pend_q[$];
    int          cur_size = 0;
    int          req_rows = 0;
    int          acc_words = 0;
    int          acc_at_req1 = -1;
    int          out_cnt = 0;
    int          eof_cyc = -100;
    int          busy_mode = 0;   // 0 low, 1 random, 2 high
    int          out_mode = 0;    // 0 always ready, 1 toggle, 2 random
    int          vld_mode = 0;    // 0 back-to-back, 1 random gaps

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents are a fixed function of the byte address.
    function automatic logic [31:0] mix(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ (a >> 7) ^ 32'h5A5A1234;
    endfunction

    // Reference model: the frame is the row-major list of SIZE*SIZE words.
    task automatic model_frame(input int s, input logic [31:0] a);
        exp_t e;
        for (int r = 0; r < s; r++) begin
            req_q.push_back(a + 32'(r * s * 4));
            for (int c = 0; c < s; c++) begin
                e.data = mix(a + 32'((r * s + c) * 4));
                e.row  = 16'(r);
                e.col  = 16'(c);
                e.eol  = (c == s - 1);
                e.eof  = (c == s - 1) && (r == s - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Drivers change inputs 1ns after the rising edge.
    initial begin : busy_drv
        READ_BUSY = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (busy_mode)
                0:       READ_BUSY = 1'b0;
                1:       READ_BUSY = ($urandom_range(0, 2) == 0);
                default: READ_BUSY = 1'b1;
            endcase
        end
    end

    initial begin : ready_drv
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK); #1;
            case (out_mode)
                0:       OUT_READY = 1'b1;
                1:       OUT_READY = ~OUT_READY;
                default: OUT_READY = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // FIFO responder: checks each request, then streams that row's words.
    initial begin : responder
        bit          fire;
        logic [31:0] ea;
        READ_VALID = 1'b0;
        READ_DATA  = '0;
        forever begin
            @(negedge CLK);
            fire = READ_VALID && READ_READY;
            if (READ_REQ) begin
                check("req_busy_low", READ_BUSY, 0);
                if (req_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    ea = req_q.pop_front();
                    check("req_addr", READ_ADDR, ea);
                end
                check("req_count", READ_COUNT, cur_size);
                if (req_rows == 1) acc_at_req1 = acc_words;
`ifdef STENCIL_ROW_PREFETCH_EN
                check("req_outstanding", (req_rows - acc_words / cur_size) < 2, 1);
`else
                check("req_row_drained", acc_words, req_rows * cur_size);
`endif
                for (int c = 0; c < cur_size; c++)
                    pend_q.push_back(READ_ADDR + 32'(c * 4));
                req_rows++;
            end
            @(posedge CLK); #1;
            if (fire && pend_q.size() > 0) begin
                void'(pend_q.pop_front());
                acc_words++;
            end
            if (pend_q.size() > 0 && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
                READ_VALID = 1'b1;
                READ_DATA  = mix(pend_q[0]);
            end else begin
                READ_VALID = 1'b0;
                READ_DATA  = $urandom;
            end
        end
    end

    // Output monitor: pops the scoreboard on every datapath handshake.
    initial begin : out_mon
        bit           prev_stall;
        logic [98:0]  snap;
        exp_t         e;
        prev_stall = 1'b0;
        snap = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall)
                check("out_hold", {OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL, OUT_EOL, OUT_EOF}, snap);
            if (OUT_VALID && OUT_READY) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {OUT_DATA, OUT_ROW, OUT_COL, OUT_EOL, OUT_EOF},
                          {e.data, e.row, e.col, e.eol, e.eof});
                end
                if (OUT_EOF) eof_cyc = cyc;
            end
            prev_stall = OUT_VALID && !OUT_READY;
            snap = {OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL, OUT_EOL, OUT_EOF};
        end
    end

    task automatic start_frame(input int s, input logic [31:0] a);
        @(posedge CLK); #1;
        cur_size    = s;
        req_rows    = 0;
        acc_words   = 0;
        acc_at_req1 = -1;
        model_frame(s, a);
        GO   = 1'b1;
        SIZE = 16'(s);
        SRC  = a;
        @(posedge CLK); #1;
        GO   = 1'b0;
        SIZE = 16'($urandom);
        SRC  = $urandom;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 3000);
        check({tag, "_done"}, DONE, 1);
        if (DONE) check({tag, "_done_lat"}, cyc, eof_cyc + 1);
        check({tag, "_out_left"}, exp_q.size(), 0);
        check({tag, "_req_left"}, req_q.size(), 0);
        @(negedge CLK);
        check({tag, "_idle_not_ready"}, READ_READY, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_side"}, {READ_REQ, READ_ADDR, READ_COUNT, READ_READY, DONE}, 0);
        check({tag, "_out_side"}, {OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL, OUT_EOL, OUT_EOF}, 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        int n;
        int s;
        RST = 1'b1; GO = 1'b0; SIZE = '0; SRC = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // Empty grid: DONE right away, no request.
        start_frame(0, 32'h2000);
        @(negedge CLK);
        check("size0_done", DONE, 1);
        repeat (4) @(negedge CLK);
        check("size0_no_req", req_rows, 0);

        // Directed 4x4 frame at 0x1000, full throughput.
        start_frame(4, 32'h1000);
        @(negedge CLK);
        check("frame4_done_cleared", DONE, 0);
        wait_done("frame4");

        // 3x3 with the datapath stalling every other cycle.
        out_mode = 1;
        start_frame(3, 32'h0004_0000);
        wait_done("stall3");
        out_mode = 0;

        // READ_BUSY held high: no request until it falls.
        busy_mode = 2;
        repeat (2) @(posedge CLK);
        start_frame(3, 32'h0000_3000);
        repeat (10) @(negedge CLK);
        check("busy_no_req", req_rows, 0);
        @(posedge CLK); #2;
        busy_mode = 0;
        READ_BUSY = 1'b0;
        @(negedge CLK);
        check("busy_req_after_fall", READ_REQ, 1);
        wait_done("busy3");

        // GO while a frame is running is ignored.
        start_frame(5, 32'h0000_8000);
        repeat (3) @(posedge CLK);
        #1; GO = 1'b1; SIZE = 16'd2; SRC = 32'hDEAD_0000;
        @(posedge CLK); #1; GO = 1'b0;
        wait_done("go_ignored");

        // 8x8: with prefetch the second row is requested before row 0 ends.
        start_frame(8, 32'h0001_0000);
        wait_done("frame8");
`ifdef STENCIL_ROW_PREFETCH_EN
        check("prefetch_row1_early", (acc_at_req1 >= 0) && (acc_at_req1 < 8), 1);
`else
        check("row1_after_row0", acc_at_req1, 8);
`endif

        // Randomized frames, including an address that wraps past 2^32.
        for (int i = 0; i < 12; i++) begin
            busy_mode = $urandom_range(0, 1);
            out_mode  = $urandom_range(0, 2);
            vld_mode  = $urandom_range(0, 1);
            s = $urandom_range(1, 6);
            start_frame(s, (i == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC));
            wait_done("rand");
        end
        busy_mode = 0; out_mode = 0; vld_mode = 0;

        // Reset in the middle of a frame, then a clean frame.
        n = out_cnt;
        start_frame(4, 32'h0002_0000);
        begin
            int t;
            t = 0;
            while (out_cnt < n + 5 && t < 500) begin
                @(negedge CLK);
                t++;
            end
            check("midrst_reached_5", out_cnt >= n + 5, 1);
        end
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        req_q.delete();
        pend_q.delete();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        start_frame(4, 32'h0003_0000);
        @(negedge CLK);
        check("after_rst_done_low", DONE, 0);
        wait_done("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
